// File: rtl/irom_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// irom_arbiter_pkg
// Shared definitions for the instruction-ROM arbiter: FSM state encoding,
// requester port indices and default widths.
// ---------------------------------------------------------------------------
package irom_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEF_DWIDTH  = 16;
    localparam int DEF_AWIDTH  = 12;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/irom_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// irom_arbiter_rr_arb2
// Combinational two-way round-robin pick.
//   req_i        [1:0]  request vector, bit index = port index
//   last_grant_i        port that owned the previous transaction
//   gnt_o        [1:0]  one-hot grant (all zero when no request)
// With both ports requesting, the port that did not win last time is chosen.
// ---------------------------------------------------------------------------
module irom_arbiter_rr_arb2
    import irom_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o[PORT_CPU] = 1'b1;
            2'b10:   gnt_o[PORT_DBG] = 1'b1;
            2'b11: begin
                if (last_grant_i == PORT_CPU) gnt_o[PORT_DBG] = 1'b1;
                else                          gnt_o[PORT_CPU] = 1'b1;
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/irom_arbiter.sv
// ---------------------------------------------------------------------------
// irom_arbiter
// Shares the instruction ROM between the CPU fetch port (m0) and the
// debug/loader port (m1). One ROM transaction in flight at a time, round-robin
// between the ports, response routed back to the port that owns it.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   m0_req/m0_addr              port 0 level request + word address
//   m0_valid/m0_data/m0_err     port 0 one-cycle response strobe, data, timeout
//   m1_*                        same for port 1
//   rom_addr/rom_ready          address + one-cycle request strobe to irom
//   rom_dout/rom_valid          irom read data + data strobe
//
// Build option
//   IROM_ARB_TIMEOUT_EN  when defined, a transaction that sees no rom_valid
//                        within TIMEOUT wait cycles completes with err=1 and
//                        data=0. Otherwise m0_err/m1_err are constant 0.
//
// State | meaning
// IDLE  | pick an owner among requesting ports, latch its address
// ISSUE | rom_ready high for one cycle, remember owner for fairness
// WAIT  | wait for rom_valid (or timeout), capture data for the owner
// RESP  | owner's valid strobe high for one cycle
// ---------------------------------------------------------------------------
module irom_arbiter
    import irom_arbiter_pkg::*;
#(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int AWIDTH  = DEF_AWIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [AWIDTH-1:0] m0_addr,
    output logic              m0_valid,
    output logic [DWIDTH-1:0] m0_data,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [AWIDTH-1:0] m1_addr,
    output logic              m1_valid,
    output logic [DWIDTH-1:0] m1_data,
    output logic              m1_err,
    output logic [AWIDTH-1:0] rom_addr,
    output logic              rom_ready,
    input  logic [DWIDTH-1:0] rom_dout,
    input  logic              rom_valid
);

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("irom_arbiter: TIMEOUT must be at least 2");
    end

    arb_state_e        state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [AWIDTH-1:0] rom_addr_q;
    logic              rom_ready_q;
    logic              m0_valid_q, m1_valid_q;
    logic [DWIDTH-1:0] m0_data_q, m1_data_q;
    logic [1:0]        gnt;
    logic              expired;

    irom_arbiter_rr_arb2 u_rr_arb2 (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

`ifdef IROM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q;
    logic             m0_err_q, m1_err_q;

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign m0_err  = m0_err_q;
    assign m1_err  = m1_err_q;
`else
    assign expired = 1'b0;
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_CPU;
            last_grant_q <= PORT_DBG;   // so port 0 wins the first tie
            rom_addr_q   <= '0;
            rom_ready_q  <= 1'b0;
            m0_valid_q   <= 1'b0;
            m1_valid_q   <= 1'b0;
            m0_data_q    <= '0;
            m1_data_q    <= '0;
`ifdef IROM_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // rom_valid here is a stale answer and is ignored
                    if (|gnt) begin
                        owner_q     <= gnt[PORT_DBG];
                        rom_addr_q  <= gnt[PORT_DBG] ? m1_addr : m0_addr;
                        rom_ready_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rom_ready_q  <= 1'b0;
                    last_grant_q <= owner_q;
`ifdef IROM_ARB_TIMEOUT_EN
                    cnt_q        <= '0;
`endif
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // rom_valid takes priority over a same-cycle expiry
                    if (rom_valid || expired) begin
                        if (owner_q == PORT_CPU) begin
                            m0_valid_q <= 1'b1;
                            m0_data_q  <= rom_valid ? rom_dout : '0;
                        end else begin
                            m1_valid_q <= 1'b1;
                            m1_data_q  <= rom_valid ? rom_dout : '0;
                        end
`ifdef IROM_ARB_TIMEOUT_EN
                        m0_err_q <= (owner_q == PORT_CPU) && !rom_valid;
                        m1_err_q <= (owner_q == PORT_DBG) && !rom_valid;
`endif
                        state_q <= ST_RESP;
                    end
`ifdef IROM_ARB_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    m0_valid_q <= 1'b0;
                    m1_valid_q <= 1'b0;
`ifdef IROM_ARB_TIMEOUT_EN
                    m0_err_q   <= 1'b0;
                    m1_err_q   <= 1'b0;
`endif
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_ready = rom_ready_q;
    assign m0_valid  = m0_valid_q;
    assign m1_valid  = m1_valid_q;
    assign m0_data   = m0_data_q;
    assign m1_data   = m1_data_q;

endmodule

// File: tb/tb_irom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_irom_arbiter
// Directed stimulus with a scoreboard: the stimulus pushes the expected ROM
// issues and port responses (address/data/cycle) into queues, and a monitor
// pops and compares whenever rom_ready or an mN_valid appears. A small ROM
// model answers rom_ready after a programmable latency.
// ---------------------------------------------------------------------------
module tb_irom_arbiter;

`ifdef IROM_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    typedef struct {
        logic [11:0] addr;
        int          cyc;
    } iss_t;

    typedef struct {
        logic        port;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [11:0] m0_addr, m1_addr;
    logic        m0_valid, m1_valid, m0_err, m1_err;
    logic [15:0] m0_data, m1_data;
    logic [11:0] rom_addr;
    logic        rom_ready;
    logic [15:0] rom_dout;
    logic        rom_valid;

    int    cyc      = 0;
    int    checks   = 0;
    int    errors   = 0;
    int    n_resp   = 0;
    int    rom_lat  = 1;
    logic  rom_mute = 1'b0;
    int    late_req = 0;
    iss_t  iss_q[$];
    resp_t resp_q[$];

    irom_arbiter #(
        .DWIDTH  (16),
        .AWIDTH  (12),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_valid  (m0_valid),
        .m0_data   (m0_data),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_valid  (m1_valid),
        .m1_data   (m1_data),
        .m1_err    (m1_err),
        .rom_addr  (rom_addr),
        .rom_ready (rom_ready),
        .rom_dout  (rom_dout),
        .rom_valid (rom_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_word(input logic [11:0] a);
        case (a)
            12'h010: return 16'hBEEF;
            12'h001: return 16'h1111;
            12'h002: return 16'h2222;
            12'h020: return 16'h5A5A;
            12'h030: return 16'hC0DE;
            12'h100: return 16'hA100;
            12'h101: return 16'hA101;
            12'h102: return 16'hA102;
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    task automatic push_iss(input logic [11:0] a, input int c);
        iss_t e;
        e.addr = a;
        e.cyc  = c;
        iss_q.push_back(e);
    endtask

    task automatic push_resp(input logic p, input logic [15:0] d, input logic er, input int c);
        resp_t e;
        e.port = p;
        e.data = d;
        e.err  = er;
        e.cyc  = c;
        resp_q.push_back(e);
    endtask

    // Returns just after the posedge that follows the target response.
    task automatic wait_nresp(input int target, input int budget);
        int n;
        n = 0;
        while (n_resp < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n_resp < target) flag("wait_resp_timeout", 32'(n_resp));
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ROM model
    initial begin : rom_model
        int          late_done;
        logic [11:0] a;
        late_done = 0;
        rom_valid = 1'b0;
        rom_dout  = '0;
        forever begin
            @(negedge clk);
            if (late_req != late_done) begin
                late_done = late_req;
                @(posedge clk);
                #1;
                rom_valid = 1'b1;
                rom_dout  = 16'h7777;
                @(posedge clk);
                #1;
                rom_valid = 1'b0;
            end else if (rom_ready && !rom_mute && rst_n) begin
                a = rom_addr;
                repeat (rom_lat) @(posedge clk);
                #1;
                rom_valid = 1'b1;
                rom_dout  = rom_word(a);
                @(posedge clk);
                #1;
                rom_valid = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        iss_t  ei;
        resp_t er;
        forever begin
            @(negedge clk);
            if (rom_ready) begin
                if (iss_q.size() == 0) begin
                    flag("unexpected_rom_ready", 32'(rom_addr));
                end else begin
                    ei = iss_q.pop_front();
                    chk("issue_addr", 32'(rom_addr), 32'(ei.addr));
                    chk("issue_cycle", cyc, ei.cyc);
                end
            end
            if (m0_valid && m1_valid) flag("both_valid", 32'(2'b11));
            if (m0_valid || m1_valid) begin
                n_resp++;
                if (resp_q.size() == 0) begin
                    flag("unexpected_resp", {15'd0, m1_valid, m1_valid ? m1_data : m0_data});
                end else begin
                    er = resp_q.pop_front();
                    chk("resp_port", 32'(m1_valid), 32'(er.port));
                    chk("resp_data", 32'(m1_valid ? m1_data : m0_data), 32'(er.data));
                    chk("resp_err",  32'(m1_valid ? m1_err : m0_err), 32'(er.err));
                    chk("resp_cycle", cyc, er.cyc);
                end
            end
        end
    end

    initial begin : stimulus
        int c0;
        int base;
        logic [11:0] b2b_addr [3];
        logic [15:0] b2b_data [3];
        b2b_addr[0] = 12'h100; b2b_addr[1] = 12'h101; b2b_addr[2] = 12'h102;
        b2b_data[0] = 16'hA100; b2b_data[1] = 16'hA101; b2b_data[2] = 16'hA102;

        rst_n   = 1'b0;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        m0_addr = '0;
        m1_addr = '0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // reset state
        @(negedge clk);
        chk("rst_rom_ready", 32'(rom_ready), 0);
        chk("rst_rom_addr",  32'(rom_addr), 0);
        chk("rst_m0_valid",  32'(m0_valid), 0);
        chk("rst_m1_valid",  32'(m1_valid), 0);
        chk("rst_m0_data",   32'(m0_data), 0);
        chk("rst_m1_data",   32'(m1_data), 0);
        chk("rst_m0_err",    32'(m0_err), 0);
        chk("rst_m1_err",    32'(m1_err), 0);
        next_cycle();

        // single port, L=1
        c0 = cyc;
        m0_req  = 1'b1;
        m0_addr = 12'h010;
        push_iss(12'h010, c0 + 1);
        push_resp(1'b0, 16'hBEEF, 1'b0, c0 + 3);
        wait_nresp(1, 20);
        m0_req = 1'b0;
        repeat (4) next_cycle();

        // contention from reset: grants 0,1,0,1
        rst_n = 1'b0;
        m0_req  = 1'b1; m0_addr = 12'h001;
        m1_req  = 1'b1; m1_addr = 12'h002;
        next_cycle();
        rst_n = 1'b1;
        c0 = cyc;
        base = n_resp;
        for (int k = 0; k < 4; k++) begin
            push_iss((k % 2 == 0) ? 12'h001 : 12'h002, c0 + 1 + 4 * k);
            push_resp(k[0], (k % 2 == 0) ? 16'h1111 : 16'h2222, 1'b0, c0 + 3 + 4 * k);
        end
        wait_nresp(base + 4, 40);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (4) next_cycle();

        // request dropped before grant, L=3
        rom_lat = 3;
        c0 = cyc;
        base = n_resp;
        m0_req  = 1'b1;
        m0_addr = 12'h020;
        push_iss(12'h020, c0 + 1);
        push_resp(1'b0, 16'h5A5A, 1'b0, c0 + 5);
        next_cycle();
        next_cycle();
        m1_req  = 1'b1;
        m1_addr = 12'h030;
        next_cycle();
        m1_req  = 1'b0;
        wait_nresp(base + 1, 20);
        m0_req = 1'b0;
        repeat (8) next_cycle();

        // reset in WAIT, then a late rom_valid
        rom_lat  = 1;
        rom_mute = 1'b1;
        c0 = cyc;
        m0_req  = 1'b1;
        m0_addr = 12'h040;
        push_iss(12'h040, c0 + 1);
        repeat (3) next_cycle();
        rst_n  = 1'b0;
        m0_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        late_req++;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("post_rst_rom_ready", 32'(rom_ready), 0);
        chk("post_rst_rom_addr",  32'(rom_addr), 0);
        chk("post_rst_m0_valid",  32'(m0_valid), 0);
        chk("post_rst_m0_data",   32'(m0_data), 0);
        chk("post_rst_m1_data",   32'(m1_data), 0);
        next_cycle();
        rom_mute = 1'b0;
        // FSM must be in IDLE: fresh request sees nominal latency
        c0 = cyc;
        base = n_resp;
        m0_req  = 1'b1;
        m0_addr = 12'h010;
        push_iss(12'h010, c0 + 1);
        push_resp(1'b0, 16'hBEEF, 1'b0, c0 + 3);
        wait_nresp(base + 1, 20);
        m0_req = 1'b0;
        repeat (4) next_cycle();

        // back-to-back on port 0, L=1: issues 4 cycles apart
        c0 = cyc;
        base = n_resp;
        m0_req  = 1'b1;
        m0_addr = b2b_addr[0];
        for (int k = 0; k < 3; k++) begin
            push_iss(b2b_addr[k], c0 + 1 + 4 * k);
            push_resp(1'b0, b2b_data[k], 1'b0, c0 + 3 + 4 * k);
        end
        for (int k = 0; k < 3; k++) begin
            wait_nresp(base + k + 1, 20);
            if (k < 2) m0_addr = b2b_addr[k + 1];
            else       m0_req  = 1'b0;
        end
        repeat (4) next_cycle();

`ifdef IROM_ARB_TIMEOUT_EN
        // ROM never answers: err response after 8 WAIT cycles, late data dropped
        rom_mute = 1'b1;
        c0 = cyc;
        base = n_resp;
        m0_req  = 1'b1;
        m0_addr = 12'h050;
        push_iss(12'h050, c0 + 1);
        push_resp(1'b0, 16'h0000, 1'b1, c0 + 10);
        wait_nresp(base + 1, 30);
        m0_req = 1'b0;
        late_req++;
        repeat (6) next_cycle();
        rom_mute = 1'b0;
`endif

        repeat (2) next_cycle();
        chk("queues_drained", 32'(iss_q.size() + resp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
